// File: rtl/cordic_angle_prep.sv
// IEEE-754 single angle to signed Q2.30 converter with iteration-count clamp for the CORDIC core.
// Optional build macro CORDIC_PREP_ROUND_EN: round-to-nearest (ties away) on the aligned magnitude.
module cordic_angle_prep #(
  parameter int SHIFT_STEP = 4,
  parameter int N_MAX      = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] theta,
  input  logic [5:0]  n_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] angle,
  output logic [5:0]  n_out,
  output logic        range_err,
  output logic [1:0]  state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and outputs stay stable while valid is high and ready is low.
  typedef enum logic [1:0] {IDLE, SHIFT, NEG, DONE} state_t;

  localparam logic [4:0] STEP   = 5'(SHIFT_STEP);
  localparam logic [5:0] N_CLAMP = 6'(N_MAX);

  state_t      state_q, state_d;
  logic        sign_q, sat_q, err_q;
  logic [30:0] mag_q;
  logic [4:0]  cnt_q;
  logic [31:0] angle_q;
  logic [5:0]  n_q;

  logic [7:0]  exp_f;
  logic [22:0] man_f;
  logic [4:0]  k;
  logic [30:0] mag_shift;

  assign exp_f = theta[30:23];
  assign man_f = theta[22:0];

  assign k         = (cnt_q < STEP) ? cnt_q : STEP;
  assign mag_shift = mag_q >> k;

`ifdef CORDIC_PREP_ROUND_EN
  logic        rnd_q;
  logic [30:0] mag_pre;
  logic        rbit;
  // Last bit to fall off in this step sits at position k-1 of the current magnitude.
  assign mag_pre = (k == 5'd0) ? 31'd0 : (mag_q >> (k - 5'd1));
  assign rbit    = mag_pre[0];
`endif

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (exp_f >= 8'd96 && exp_f <= 8'd127) state_d = SHIFT;
          else                                   state_d = NEG;
        end
      end
      SHIFT: if (cnt_q == 5'd0) state_d = NEG;
      NEG:   state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_q  <= 1'b0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
      mag_q   <= 31'd0;
      cnt_q   <= 5'd0;
      angle_q <= 32'd0;
      n_q     <= 6'd0;
`ifdef CORDIC_PREP_ROUND_EN
      rnd_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sign_q <= theta[31];
          n_q    <= (n_in > N_CLAMP) ? N_CLAMP : n_in;
          sat_q  <= 1'b0;
          err_q  <= 1'b0;
          mag_q  <= {1'b1, man_f, 7'b0};
          cnt_q  <= 5'(8'd127 - exp_f);
`ifdef CORDIC_PREP_ROUND_EN
          rnd_q  <= 1'b0;
`endif
          if (exp_f == 8'd255) begin
            err_q <= 1'b1;
            if (man_f == 23'd0) sat_q <= 1'b1;
            else                mag_q <= 31'd0;
          end else if (exp_f >= 8'd128) begin
            err_q <= 1'b1;
            sat_q <= 1'b1;
          end else if (exp_f < 8'd96) begin
            mag_q <= 31'd0;
          end
        end
        SHIFT: begin
          if (cnt_q != 5'd0) begin
            mag_q <= mag_shift;
            cnt_q <= cnt_q - k;
`ifdef CORDIC_PREP_ROUND_EN
            rnd_q <= rbit;
`endif
          end else begin
`ifdef CORDIC_PREP_ROUND_EN
            mag_q <= mag_q + {30'd0, rnd_q};
`endif
          end
        end
        NEG: begin
          if (sat_q)       angle_q <= sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
          else if (sign_q) angle_q <= -{1'b0, mag_q};
          else             angle_q <= {1'b0, mag_q};
        end
        default: ;
      endcase
    end
  end

  assign angle     = angle_q;
  assign n_out     = n_q;
  assign range_err = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cordic_angle_prep.sv
// Directed bench for cordic_angle_prep: vector table plus backpressure and mid-conversion reset sequences.
module tb_cordic_angle_prep;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] theta;
  logic [5:0]  n_in;
  logic        out_valid, out_ready;
  logic [31:0] angle;
  logic [5:0]  n_out;
  logic        range_err;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] theta;
    logic [5:0]  n_in;
    logic [31:0] exp_angle;
    logic [5:0]  exp_n;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

`ifdef CORDIC_PREP_ROUND_EN
  localparam logic [31:0] TINY_EXP = 32'd1;
`else
  localparam logic [31:0] TINY_EXP = 32'd0;
`endif

  cordic_angle_prep #(.SHIFT_STEP(4), .N_MAX(30)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .theta(theta), .n_in(n_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .angle(angle), .n_out(n_out), .range_err(range_err),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one input, measures latency (accept edge counts as cycle 1), checks outputs.
  // Leaves the block in DONE; caller decides when out_ready completes the handshake.
  task automatic send_and_wait(input vec_t v, input string tag);
    int cyc;
    @(negedge clk);
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    theta    = v.theta;
    n_in     = v.n_in;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(v.exp_lat));
    chk({tag, " angle"}, angle, v.exp_angle);
    chk({tag, " n_out"}, {26'd0, n_out}, {26'd0, v.exp_n});
    chk({tag, " range_err"}, {31'd0, range_err}, {31'd0, v.exp_err});
  endtask

  task automatic finish_handshake(input string tag);
    // out_ready is high here; the next edge completes the transfer.
    @(posedge clk);
    #1 chk({tag, " out_valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  vec_t vecs[17];
  vec_t v;

  initial begin
    vecs[0]  = '{32'hbf7f0000, 6'd4,  32'hC0400000, 6'd4,  1'b0, 4};
    vecs[1]  = '{32'h3f800000, 6'd40, 32'h40000000, 6'd30, 1'b0, 3};
    vecs[2]  = '{32'h40000000, 6'd5,  32'h7FFFFFFF, 6'd5,  1'b1, 2};
    vecs[3]  = '{32'hff800000, 6'd31, 32'h80000000, 6'd30, 1'b1, 2};
    vecs[4]  = '{32'h7fc00000, 6'd0,  32'h00000000, 6'd0,  1'b1, 2};
    vecs[5]  = '{32'h30000000, 6'd63, TINY_EXP,     6'd30, 1'b0, 11};
    vecs[6]  = '{32'h00000000, 6'd30, 32'h00000000, 6'd30, 1'b0, 2};
    vecs[7]  = '{32'h3f000000, 6'd12, 32'h20000000, 6'd12, 1'b0, 4};
    vecs[8]  = '{32'hbfc00000, 6'd29, 32'hA0000000, 6'd29, 1'b0, 3};
    vecs[9]  = '{32'h3fffffff, 6'd1,  32'h7FFFFF80, 6'd1,  1'b0, 3};
    vecs[10] = '{32'h00000001, 6'd2,  32'h00000000, 6'd2,  1'b0, 2};
    vecs[11] = '{32'h80000000, 6'd3,  32'h00000000, 6'd3,  1'b0, 2};
    vecs[12] = '{32'h2f800000, 6'd3,  32'h00000000, 6'd3,  1'b0, 2};
    vecs[13] = '{32'hc0000000, 6'd7,  32'h80000000, 6'd7,  1'b1, 2};
    vecs[14] = '{32'h7f7fffff, 6'd8,  32'h7FFFFFFF, 6'd8,  1'b1, 2};
    vecs[15] = '{32'h32000000, 6'd9,  32'h00000008, 6'd9,  1'b0, 10};
    vecs[16] = '{32'hb2000000, 6'd9,  32'hFFFFFFF8, 6'd9,  1'b0, 10};

    reset = 1'b1; in_valid = 1'b0; theta = '0; n_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst angle", angle, 32'd0);
    chk("rst n_out", {26'd0, n_out}, 32'd0);
    chk("rst range_err", {31'd0, range_err}, 32'd0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      send_and_wait(vecs[i], $sformatf("vec%0d", i));
      finish_handshake($sformatf("vec%0d", i));
    end

    // Backpressure: hold output for 5 cycles while a second input waits.
    out_ready = 1'b0;
    v = '{32'h3f000000, 6'd10, 32'h20000000, 6'd10, 1'b0, 4};
    send_and_wait(v, "bp");
    @(negedge clk);
    in_valid = 1'b1; theta = 32'h3f800000; n_in = 6'd20;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp hold out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp hold angle", angle, 32'h20000000);
      chk("bp hold n_out", {26'd0, n_out}, 32'd10);
      chk("bp hold range_err", {31'd0, range_err}, 32'd0);
      chk("bp hold in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp handshake out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp handshake in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp not yet accepted", {30'd0, state_dbg}, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp second accepted", {31'd0, in_ready}, 32'd0);
    begin : wait2
      int cyc;
      cyc = 1;
      while (!out_valid && cyc < 40) begin
        @(posedge clk);
        #1 cyc++;
      end
      chk("bp2 latency", 32'(cyc), 32'd3);
      chk("bp2 angle", angle, 32'h40000000);
      chk("bp2 n_out", {26'd0, n_out}, 32'd20);
    end
    finish_handshake("bp2");

    // Reset while shifting a long-shift input.
    @(negedge clk);
    in_valid = 1'b1; theta = 32'h30000000; n_in = 6'd5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("rstmid in SHIFT", {30'd0, state_dbg}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rstmid out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid angle", angle, 32'd0);
    chk("rstmid n_out", {26'd0, n_out}, 32'd0);
    @(negedge clk) reset = 1'b0;
    #1 chk("rstmid in_ready", {31'd0, in_ready}, 32'd1);
    repeat (12) begin
      @(posedge clk);
      #1 chk("rstmid no output", {31'd0, out_valid}, 32'd0);
    end
    send_and_wait(vecs[0], "post_rst");
    finish_handshake("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
